axi_sram_slave: RTL and testbench

AXI3 slave that answers burst read and write transactions from a single 32-bit synchronous SRAM port. It is the responder matching the cache-side AXI masters: the instruction cache issues 16-beat INCR read bursts, and this block serves them from on-chip memory. It is used as a boot/scratch memory and as the bench-side memory model for cache verification. One transaction is in service at a time, and reads and writes share the single memory port.

---
 rtl/axi_sram_slave.sv | 154 +++++++++++++++
 tb/tb_axi_sram_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 burst slave that serves reads and writes from a single 32-bit synchronous SRAM port.
// One transaction is in service at a time; a pending read wins over a pending write.
module axi_sram_slave #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    // read address / data
    input  logic [3:0]        s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [3:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [3:0]        s_rid,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    // write address / data / response
    input  logic [3:0]        s_awid,
    input  logic [31:0]       s_awaddr,
    input  logic [3:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [3:0]        s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    // SRAM port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_t;

    state_t            state;
    logic [3:0]        id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        cnt_q;
    logic              fixed_q;
    logic              issue_left_q;

    logic              rd_issue;
    logic              r_hs;
    logic              w_hs;
    logic [ADDR_W-1:0] addr_next;

    // Size, wlast and the out-of-range address bits carry no information for this memory.
    logic unused_ok;
    assign unused_ok = ^{s_arsize, s_awsize, s_wlast,
                         s_araddr[31:ADDR_W+2], s_araddr[1:0],
                         s_awaddr[31:ADDR_W+2], s_awaddr[1:0]};

    assign s_arready = (state == IDLE) && !rst;
    assign s_awready = (state == IDLE) && !rst && !s_arvalid;
    assign s_wready  = (state == WR);
    assign s_rid     = id_q;
    assign s_bid     = id_q;
    assign s_rresp   = 2'b00;
    assign s_bresp   = 2'b00;
    assign s_rdata   = mem_rdata;

    // A read is issued only when the R slot is free or being emptied this cycle,
    // so the SRAM output register doubles as the R data holding register.
    assign r_hs      = s_rvalid && s_rready;
    assign rd_issue  = (state == RD) && issue_left_q && (!s_rvalid || s_rready);
    assign w_hs      = (state == WR) && s_wvalid;
    assign addr_next = fixed_q ? addr_q : addr_q + ADDR_W'(1);

    assign mem_en    = rd_issue || w_hs;
    assign mem_we    = w_hs ? s_wstrb : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = s_wdata;

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            fixed_q      <= 1'b0;
            issue_left_q <= 1'b0;
            s_rvalid     <= 1'b0;
            s_rlast      <= 1'b0;
            s_bvalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_arvalid) begin
                        id_q         <= s_arid;
                        addr_q       <= s_araddr[ADDR_W+1:2];
                        cnt_q        <= s_arlen;
                        fixed_q      <= (s_arburst == 2'b00);
                        issue_left_q <= 1'b1;
                        state        <= RD;
                    end else if (s_awvalid) begin
                        id_q    <= s_awid;
                        addr_q  <= s_awaddr[ADDR_W+1:2];
                        cnt_q   <= s_awlen;
                        fixed_q <= (s_awburst == 2'b00);
                        state   <= WR;
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        addr_q       <= addr_next;
                        cnt_q        <= cnt_q - 4'd1;
                        issue_left_q <= (cnt_q != 4'd0);
                        s_rvalid     <= 1'b1;
                        s_rlast      <= (cnt_q == 4'd0);
                    end else if (r_hs) begin
                        s_rvalid <= 1'b0;
                        s_rlast  <= 1'b0;
                        if (s_rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                WR: begin
                    if (s_wvalid) begin
                        addr_q <= addr_next;
                        cnt_q  <= cnt_q - 4'd1;
                        if (cnt_q == 4'd0) begin
                            s_bvalid <= 1'b1;
                            state    <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: drivers push expected R/B responses into queues,
// a negedge monitor pops and compares them as the DUT presents each handshake.
module tb_axi_sram_slave;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        s_arid = '0;
    logic [31:0]       s_araddr = '0;
    logic [3:0]        s_arlen = '0;
    logic [2:0]        s_arsize = 3'b010;
    logic [1:0]        s_arburst = 2'b01;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [3:0]        s_rid;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready = 1'b0;
    logic [3:0]        s_awid = '0;
    logic [31:0]       s_awaddr = '0;
    logic [3:0]        s_awlen = '0;
    logic [2:0]        s_awsize = 3'b010;
    logic [1:0]        s_awburst = 2'b01;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [31:0]       s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_wlast = 1'b0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [3:0]        s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready = 1'b0;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous SRAM: read data registered on enable, held otherwise.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } r_beat_t;

    r_beat_t    exp_r[$];
    logic [3:0] exp_b[$];

    // Monitor state
    int          ar_cyc = 0, w_cyc = 0, rl_cyc = 0, r_beats = 0, cur_len = 0;
    bit          first_pending = 0, chk_b2b = 0, chk_aw_after = 0;
    bit          prev_stall = 0, prev_bvalid = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    r_beat_t     mon_e;
    logic [3:0]  mon_b;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall    = 0;
            prev_bvalid   = 0;
            first_pending = 0;
        end else begin
            if (prev_stall)
                check("r_stable", {s_rvalid, s_rlast, s_rdata}, {1'b1, prev_last, prev_data});
            prev_stall = s_rvalid && !s_rready;
            prev_data  = s_rdata;
            prev_last  = s_rlast;

            if (s_arvalid && s_arready) begin
                ar_cyc        = cyc;
                first_pending = 1;
            end
            if (first_pending && s_rvalid) begin
                check("r_first_latency", cyc, ar_cyc + 2);
                first_pending = 0;
            end

            if (s_rvalid && s_rready) begin
                r_beats++;
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat id %h data %h, expected no beat", s_rid, s_rdata);
                end else begin
                    mon_e = exp_r.pop_front();
                    check("r_beat", {s_rid, s_rdata, s_rresp, s_rlast},
                          {mon_e.id, mon_e.data, 2'b00, mon_e.last});
                end
                if (s_rlast) begin
                    rl_cyc = cyc;
                    if (chk_b2b) check("r_end_cycle", cyc, ar_cyc + 2 + cur_len);
                end
            end

            if (s_awvalid && s_awready && chk_aw_after)
                check("aw_after_rlast", cyc, rl_cyc + 1);
            if (s_wvalid && s_wready) w_cyc = cyc;
            if (s_bvalid && !prev_bvalid) check("b_latency", cyc, w_cyc + 1);
            prev_bvalid = s_bvalid;

            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected: got bid %h, expected no response", s_bid);
                end else begin
                    mon_b = exp_b.pop_front();
                    check("b_resp", {s_bid, s_bresp}, {mon_b, 2'b00});
                end
            end
        end
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bit done = 0;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (s_arready) done = 1;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        if (!done) fail_now("ar_timeout");
    endtask

    task automatic wait_r_done(input bit stall);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            s_rready = stall ? ((k % 3) == 0) : 1'b1;
            @(posedge clk); #1;
            if (exp_r.size() == 0) done = 1;
        end
        s_rready = 1'b1;
        if (!done) fail_now("r_timeout");
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bit done = 0;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (s_awready) done = 1;
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0;
        if (!done) fail_now("aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] data [4], input logic [3:0] strb [4], input int n);
        for (int i = 0; i < n; i++) begin
            bit done = 0;
            s_wdata = data[i]; s_wstrb = strb[i]; s_wlast = (i == n - 1); s_wvalid = 1'b1;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (i == 0 && k == 0) check("wready_after_aw", s_wready, 1);
                if (s_wready) done = 1;
                @(posedge clk); #1;
            end
            if (!done) fail_now("w_timeout");
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic wait_b();
        bit seen = 0;
        bit done = 0;
        s_bready = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (s_bvalid) seen = 1;
            @(posedge clk); #1;
        end
        if (!seen) begin
            fail_now("b_timeout");
        end else begin
            @(negedge clk);
            check("b_hold", s_bvalid, 1);
            @(posedge clk); #1;
            s_bready = 1'b1;
            for (int k = 0; k < 20 && !done; k++) begin
                @(posedge clk); #1;
                if (exp_b.size() == 0) done = 1;
            end
            s_bready = 1'b0;
            if (!done) fail_now("b_handshake_timeout");
        end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        r_beat_t e;
        e.id = id; e.data = data; e.last = last;
        exp_r.push_back(e);
    endtask

    logic [31:0] wd [4];
    logic [3:0]  ws [4];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[16 + i] = 32'hA000_0000 + i;
        for (int i = 0; i < 4; i++) mem[12'h040 + i] = 32'hFFFF_FFFF;
        mem[12'hFFE] = 32'hB000_0FFE;
        mem[12'hFFF] = 32'hB000_0FFF;
        mem[12'h000] = 32'hB000_0000;
        mem[12'h001] = 32'hB000_0001;
        mem[12'h0C1] = 32'hDEAD_0001;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {s_arready, s_awready, s_rvalid, s_rlast, s_wready, s_bvalid, mem_en,
               mem_we, mem_addr, s_rid, s_bid, s_rresp, s_bresp}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {s_arready, s_awready}, 2'b11);
        @(posedge clk); #1;

        // 16-beat INCR read, rready held high
        for (int i = 0; i < 16; i++) push_r(4'd1, 32'hA000_0000 + i, i == 15);
        chk_b2b = 1; cur_len = 15; s_rready = 1'b1;
        send_ar(4'd1, 32'h0000_0040, 4'd15, 2'b01);
        wait_r_done(0);

        // Same read with rready toggling 1,0,0
        for (int i = 0; i < 16; i++) push_r(4'd2, 32'hA000_0000 + i, i == 15);
        chk_b2b = 0;
        send_ar(4'd2, 32'h0000_0040, 4'd15, 2'b01);
        wait_r_done(1);

        // 4-beat write with a partial strobe on beat 2, then read back
        wd = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 32'hCAFE_BABE};
        ws = '{4'hF, 4'hF, 4'h3, 4'hF};
        exp_b.push_back(4'd5);
        send_aw(4'd5, 32'h0000_0100, 4'd3, 2'b01);
        send_w(wd, ws, 4);
        wait_b();
        push_r(4'd6, 32'h1234_5678, 1'b0);
        push_r(4'd6, 32'h9ABC_DEF0, 1'b0);
        push_r(4'd6, 32'hFFFF_F00D, 1'b0);
        push_r(4'd6, 32'hCAFE_BABE, 1'b1);
        chk_b2b = 1; cur_len = 3;
        send_ar(4'd6, 32'h0000_0100, 4'd3, 2'b01);
        wait_r_done(0);

        // AR and AW presented together: read first, AW right after rlast
        for (int i = 0; i < 16; i++) push_r(4'd1, 32'hA000_0000 + i, i == 15);
        exp_b.push_back(4'd7);
        wd = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        chk_b2b = 1; cur_len = 15; chk_aw_after = 1;
        fork
            begin
                send_ar(4'd1, 32'h0000_0040, 4'd15, 2'b01);
                wait_r_done(0);
            end
            begin
                send_aw(4'd7, 32'h0000_0200, 4'd1, 2'b01);
                send_w(wd, ws, 2);
                wait_b();
            end
        join
        chk_aw_after = 0;
        push_r(4'd2, 32'h1111_1111, 1'b0);
        push_r(4'd2, 32'h2222_2222, 1'b1);
        cur_len = 1;
        send_ar(4'd2, 32'h0000_0200, 4'd1, 2'b01);
        wait_r_done(0);

        // Address wrap at the top of the word space
        push_r(4'd4, 32'hB000_0FFE, 1'b0);
        push_r(4'd4, 32'hB000_0FFF, 1'b0);
        push_r(4'd4, 32'hB000_0000, 1'b0);
        push_r(4'd4, 32'hB000_0001, 1'b1);
        cur_len = 3;
        send_ar(4'd4, 32'h0000_3FF8, 4'd3, 2'b01);
        wait_r_done(0);

        // FIXED write: only the last beat survives, neighbour untouched
        wd = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        exp_b.push_back(4'd8);
        send_aw(4'd8, 32'h0000_0300, 4'd3, 2'b00);
        send_w(wd, ws, 4);
        wait_b();
        push_r(4'd9, 32'h0000_0004, 1'b0);
        push_r(4'd9, 32'hDEAD_0001, 1'b1);
        cur_len = 1;
        send_ar(4'd9, 32'h0000_0300, 4'd1, 2'b01);
        wait_r_done(0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 16; i++) push_r(4'd1, 32'hA000_0000 + i, i == 15);
        chk_b2b = 0; r_beats = 0;
        send_ar(4'd1, 32'h0000_0040, 4'd15, 2'b01);
        for (int k = 0; k < 100 && r_beats < 5; k++) begin
            @(posedge clk); #1;
        end
        if (r_beats < 5) fail_now("reset_beat5_timeout");
        rst = 1'b1;
        exp_r.delete();
        s_arvalid = 1'b1;
        @(negedge clk);
        check("rst_ar_r_quiet", {s_arready, s_rvalid, mem_en}, 3'b000);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        s_awvalid = 1'b1;
        @(negedge clk);
        check("rst_aw_quiet", {s_awready, s_wready, s_bvalid}, 3'b000);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        rst = 1'b0;
        push_r(4'd3, 32'hA000_0004, 1'b1);
        chk_b2b = 1; cur_len = 0;
        send_ar(4'd3, 32'h0000_0050, 4'd0, 2'b01);
        wait_r_done(0);
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_r.size() + exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
